// File: rtl/eth_rx_word_packer_pkg.sv
// Shared Ethernet receive-path definitions: packer FSM encoding, output word
// layout and the tkeep lookup used when a frame ends on a partial word.
package eth_rx_word_packer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PACK = 2'd1,
    ST_DROP = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } axis_word_t;

  // Indexed by the lane of the final byte in the word (0 = one valid byte).
  localparam logic [3:0] KEEP_BE [4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
  localparam logic [3:0] KEEP_LE [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

  function automatic logic [3:0] keep_for_lane(input logic [1:0] lane,
                                               input logic       big_endian);
    return big_endian ? KEEP_BE[lane] : KEEP_LE[lane];
  endfunction

endpackage

// File: rtl/eth_axis_out_reg.sv
// Single-entry AXI-Stream output register; free_o tells the packer whether a
// new word may be loaded this cycle (empty, or current word leaving now).
module eth_axis_out_reg
  import eth_rx_word_packer_pkg::*;
(
  input  logic        axi_tclk_i,
  input  logic        axi_tresetn_i,
  input  logic        load_i,
  input  axis_word_t  word_i,
  output logic        free_o,
  input  logic        m_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast
);

  logic       valid_q, valid_d;
  axis_word_t word_q, word_d;

  assign free_o = ~valid_q | m_axis_tready;

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; otherwise always_comb would describe a latch.
  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    if (load_i) begin
      valid_d = 1'b1;
      word_d  = word_i;
    end else if (m_axis_tready) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // their _d values from the same edge regardless of statement order.
  always_ff @(posedge axi_tclk_i or posedge axi_tresetn_i) begin
    if (axi_tresetn_i) begin
      valid_q <= 1'b0;
      word_q  <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
    end
  end

  assign m_axis_tvalid = valid_q;
  assign m_axis_tdata  = word_q.data;
  assign m_axis_tkeep  = word_q.keep;
  assign m_axis_tlast  = word_q.last;

endmodule

// File: rtl/eth_rx_word_packer.sv
// Packs decoded RX payload bytes into 32-bit AXI-Stream words, truncating
// frames longer than MAX_BYTES and reporting per-frame length/status.
module eth_rx_word_packer
  import eth_rx_word_packer_pkg::*;
#(
  parameter logic [15:0] MAX_BYTES  = 16'd1500,
  parameter logic        BIG_ENDIAN = 1'b1
) (
  input  logic        axi_tclk_i,
  input  logic        axi_tresetn_i,
  input  logic        enable_i,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [15:0] byte_count_o,
  output logic        frame_done_o,
  output logic        frame_trunc_o
);

  rx_state_e   state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] count_q, count_d;
  logic [15:0] byte_count_q, byte_count_d;
  logic [31:0] asm_q, asm_d;
  logic        done_q, done_d;
  logic        trunc_q, trunc_d;

  logic        out_free;
  logic        load;
  axis_word_t  load_word;
  logic        byte_beat;
  logic [15:0] count_inc;
  logic        hit_max;
  logic        would_load;
  logic [1:0]  slot;
  logic [31:0] asm_next;

  // Datapath view of the current byte: where it lands and whether it ends a word.
  always_comb begin
    count_inc  = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
    hit_max    = (count_inc == MAX_BYTES);
    would_load = (lane_q == 2'd3) | s_axis_tlast | hit_max;
    slot       = BIG_ENDIAN ? ~lane_q : lane_q;
    asm_next   = asm_q;
    asm_next[{slot, 3'b000} +: 8] = s_axis_tdata;
  end

  always_comb begin
    s_axis_tready = 1'b0;
    case (state_q)
      ST_IDLE: s_axis_tready = enable_i & out_free;
      ST_PACK: s_axis_tready = ~would_load | out_free;
      ST_DROP: s_axis_tready = 1'b1;
      default: s_axis_tready = 1'b0;
    endcase
    if (axi_tresetn_i) s_axis_tready = 1'b0;
  end

  assign byte_beat = s_axis_tvalid & s_axis_tready;

  always_comb begin
    state_d        = state_q;
    lane_d         = lane_q;
    count_d        = count_q;
    asm_d          = asm_q;
    byte_count_d   = byte_count_q;
    done_d         = 1'b0;
    trunc_d        = 1'b0;
    load           = 1'b0;
    load_word.data = asm_next;
    load_word.keep = keep_for_lane(lane_q, BIG_ENDIAN);
    load_word.last = s_axis_tlast | hit_max;

    if (byte_beat) begin
      count_d = count_inc;
      case (state_q)
        ST_IDLE, ST_PACK: begin
          lane_d = lane_q + 2'd1;
          asm_d  = asm_next;
          // Clearing on load keeps unused lanes of a short final word at zero.
          if (would_load) begin
            load  = 1'b1;
            asm_d = '0;
          end
          if (s_axis_tlast)  state_d = ST_IDLE;
          else if (hit_max)  state_d = ST_DROP;
          else               state_d = ST_PACK;
        end
        ST_DROP: begin
          if (s_axis_tlast) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase

      if (s_axis_tlast) begin
        lane_d       = 2'd0;
        count_d      = '0;
        byte_count_d = count_inc;
        done_d       = 1'b1;
        trunc_d      = (state_q == ST_DROP);
      end
    end
  end

  always_ff @(posedge axi_tclk_i or posedge axi_tresetn_i) begin
    if (axi_tresetn_i) begin
      state_q      <= ST_IDLE;
      lane_q       <= '0;
      count_q      <= '0;
      asm_q        <= '0;
      byte_count_q <= '0;
      done_q       <= 1'b0;
      trunc_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      count_q      <= count_d;
      asm_q        <= asm_d;
      byte_count_q <= byte_count_d;
      done_q       <= done_d;
      trunc_q      <= trunc_d;
    end
  end

  eth_axis_out_reg u_out_reg (
    .axi_tclk_i    (axi_tclk_i),
    .axi_tresetn_i (axi_tresetn_i),
    .load_i        (load),
    .word_i        (load_word),
    .free_o        (out_free),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast)
  );

  assign byte_count_o  = byte_count_q;
  assign frame_done_o  = done_q;
  assign frame_trunc_o = trunc_q;

endmodule

// File: tb/tb_eth_rx_word_packer.sv
// Scoreboard bench: two packers (big/little endian, MAX_BYTES=8) share one
// byte stream; a frame-level model queues expected words and frame status.
module tb_eth_rx_word_packer;

  localparam logic [15:0] MAXB = 16'd8;

  logic        axi_tclk_i    = 1'b0;
  logic        axi_tresetn_i = 1'b1;
  logic        enable_i      = 1'b0;
  logic [7:0]  s_axis_tdata  = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast  = 1'b0;
  logic        m_axis_tready = 1'b1;

  logic        be_s_tready, be_valid, be_last, be_done, be_trunc;
  logic [31:0] be_data;
  logic [3:0]  be_keep;
  logic [15:0] be_count;
  logic        le_s_tready, le_valid, le_last, le_done, le_trunc;
  logic [31:0] le_data;
  logic [3:0]  le_keep;
  logic [15:0] le_count;

  eth_rx_word_packer #(.MAX_BYTES(MAXB), .BIG_ENDIAN(1'b1)) u_be (
    .axi_tclk_i(axi_tclk_i), .axi_tresetn_i(axi_tresetn_i), .enable_i(enable_i),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(be_s_tready),
    .m_axis_tdata(be_data), .m_axis_tkeep(be_keep), .m_axis_tvalid(be_valid),
    .m_axis_tlast(be_last), .m_axis_tready(m_axis_tready),
    .byte_count_o(be_count), .frame_done_o(be_done), .frame_trunc_o(be_trunc)
  );

  eth_rx_word_packer #(.MAX_BYTES(MAXB), .BIG_ENDIAN(1'b0)) u_le (
    .axi_tclk_i(axi_tclk_i), .axi_tresetn_i(axi_tresetn_i), .enable_i(enable_i),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(le_s_tready),
    .m_axis_tdata(le_data), .m_axis_tkeep(le_keep), .m_axis_tvalid(le_valid),
    .m_axis_tlast(le_last), .m_axis_tready(m_axis_tready),
    .byte_count_o(le_count), .frame_done_o(le_done), .frame_trunc_o(le_trunc)
  );

  always #5 axi_tclk_i = ~axi_tclk_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [36:0] exp_be[$];
  logic [36:0] exp_le[$];
  logic [16:0] exp_stat[$];

  int stall_cycles = 0;
  bit rand_ready   = 1'b0;
  bit aborted      = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Downstream ready: forced-low stall window, else always-ready or random.
  always @(posedge axi_tclk_i) begin
    #1;
    if (stall_cycles > 0) begin
      m_axis_tready = 1'b0;
      stall_cycles--;
    end else begin
      m_axis_tready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
    end
  end

  // Reference model: a frame forwards min(len, MAX) bytes, four per word,
  // first byte in the top (BE) or bottom (LE) lane; the final word has tlast.
  task automatic model_frame(input logic [7:0] fr[$]);
    int n   = fr.size();
    int fwd = (n > int'(MAXB)) ? int'(MAXB) : n;
    for (int w = 0; w * 4 < fwd; w++) begin
      logic [31:0] dbe = '0, dle = '0;
      logic [3:0]  kbe = '0, kle = '0;
      for (int b = 0; b < 4 && (w * 4 + b) < fwd; b++) begin
        dbe[31 - 8 * b -: 8] = fr[w * 4 + b];
        dle[8 * b +: 8]      = fr[w * 4 + b];
        kbe[3 - b] = 1'b1;
        kle[b]     = 1'b1;
      end
      exp_be.push_back({dbe, kbe, (w * 4 + 4) >= fwd});
      exp_le.push_back({dle, kle, (w * 4 + 4) >= fwd});
    end
    exp_stat.push_back({(n > 65535) ? 16'hFFFF : 16'(n), n > int'(MAXB)});
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte was accepted.
  task automatic send_byte(input logic [7:0] d, input bit last, output bit ok);
    int waited = 0;
    bit acc    = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    ok = 1'b1;
    while (!acc) begin
      @(negedge axi_tclk_i);
      acc = be_s_tready;
      @(posedge axi_tclk_i);
      #1;
      if (!acc && ++waited > 200) begin
        check("byte accept timeout", 64'(acc), 64'd1);
        ok = 1'b0;
        aborted = 1'b1;
        s_axis_tvalid = 1'b0;
        return;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] fr[$], input int max_gap, input bit rand_en);
    bit ok;
    if (aborted) return;
    model_frame(fr);
    for (int i = 0; i < fr.size(); i++) begin
      int gap = (max_gap > 0) ? $urandom_range(max_gap) : 0;
      for (int g = 0; g < gap; g++) begin
        s_axis_tvalid = 1'b0;
        @(posedge axi_tclk_i);
        #1;
      end
      enable_i = (i == 0) ? 1'b1 : (rand_en ? 1'($urandom_range(1)) : 1'b1);
      send_byte(fr[i], i == fr.size() - 1, ok);
      if (!ok) return;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_be.size() + exp_le.size() + exp_stat.size()) != 0 && n < 500) begin
      @(posedge axi_tclk_i);
      #1;
      n++;
    end
    check("drain outstanding", 64'(exp_be.size() + exp_le.size() + exp_stat.size()), 64'd0);
  endtask

  logic [36:0] prev_w [2];
  bit          prev_stall [2];

  task automatic mon_port(input int idx, input logic v, input logic [36:0] w, input string tag);
    logic [36:0] e;
    int          sz;
    if (prev_stall[idx]) begin
      check({tag, " held valid"}, 64'(v), 64'd1);
      check({tag, " held word"}, 64'(w), 64'(prev_w[idx]));
    end
    if (v && m_axis_tready) begin
      sz = (idx == 0) ? exp_be.size() : exp_le.size();
      check({tag, " word expected"}, 64'(sz != 0), 64'd1);
      if (sz != 0) begin
        e = (idx == 0) ? exp_be.pop_front() : exp_le.pop_front();
        check({tag, " word {data,keep,last}"}, 64'(w), 64'(e));
      end
    end
    prev_stall[idx] = v & ~m_axis_tready;
    prev_w[idx]     = w;
  endtask

  always @(negedge axi_tclk_i) begin
    if (axi_tresetn_i) begin
      prev_stall[0] = 1'b0;
      prev_stall[1] = 1'b0;
    end else begin
      mon_port(0, be_valid, {be_data, be_keep, be_last}, "be");
      mon_port(1, le_valid, {le_data, le_keep, le_last}, "le");
      if (be_done) begin
        logic [16:0] st;
        check("status expected", 64'(exp_stat.size() != 0), 64'd1);
        if (exp_stat.size() != 0) begin
          st = exp_stat.pop_front();
          check("be byte_count", 64'(be_count), 64'(st[16:1]));
          check("be frame_trunc", 64'(be_trunc), 64'(st[0]));
          check("le frame_done", 64'(le_done), 64'd1);
          check("le byte_count", 64'(le_count), 64'(st[16:1]));
          check("le frame_trunc", 64'(le_trunc), 64'(st[0]));
        end
      end else if (be_trunc) begin
        check("trunc without done", 64'(be_done), 64'd1);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    @(negedge axi_tclk_i);
    check({tag, " s_tready"}, 64'(be_s_tready), 64'd0);
    check({tag, " le s_tready"}, 64'(le_s_tready), 64'd0);
    check({tag, " tvalid"}, 64'(be_valid), 64'd0);
    check({tag, " tdata"}, 64'(be_data), 64'd0);
    check({tag, " tkeep"}, 64'(be_keep), 64'd0);
    check({tag, " tlast"}, 64'(be_last), 64'd0);
    check({tag, " byte_count"}, 64'(be_count), 64'd0);
    check({tag, " done/trunc"}, 64'({be_done, be_trunc}), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fr[$];
    bit ok;

    enable_i = 1'b1;
    repeat (3) @(posedge axi_tclk_i);
    #1;
    check_reset_outputs("reset");
    @(posedge axi_tclk_i);
    #1;
    axi_tresetn_i = 1'b0;
    @(posedge axi_tclk_i);
    #1;

    fr = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_frame(fr, 0, 1'b0);
    fr = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    send_frame(fr, 0, 1'b0);
    fr = {};
    for (int i = 1; i <= 12; i++) fr.push_back(8'(i));
    send_frame(fr, 0, 1'b0);
    // Back-to-back: single-byte frame then a new frame the very next cycle.
    fr = '{8'h5A};
    send_frame(fr, 0, 1'b0);
    fr = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    send_frame(fr, 0, 1'b0);
    drain();

    // With enable low in IDLE no byte may be taken.
    enable_i      = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'h77;
    s_axis_tlast  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge axi_tclk_i);
      check("idle enable low tready", 64'(be_s_tready), 64'd0);
    end
    @(posedge axi_tclk_i);
    #1;
    s_axis_tvalid = 1'b0;

    // Downstream stall of 32 cycles across an 8-byte frame.
    stall_cycles = 32;
    fr = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
    fork
      send_frame(fr, 0, 1'b0);
      begin
        repeat (12) @(negedge axi_tclk_i);
        check("stall s_tready low", 64'(be_s_tready), 64'd0);
        check("stall word pending", 64'(be_valid), 64'd1);
      end
    join
    drain();

    // Reset after three bytes of a frame; nothing from it may appear.
    enable_i = 1'b1;
    for (int i = 0; i < 3; i++) if (!aborted) send_byte(8'hC0 + 8'(i), 1'b0, ok);
    s_axis_tvalid = 1'b0;
    axi_tresetn_i = 1'b1;
    check_reset_outputs("mid-frame reset");
    @(posedge axi_tclk_i);
    #1;
    axi_tresetn_i = 1'b0;
    repeat (4) @(posedge axi_tclk_i);
    #1;
    check("post-reset no word", 64'(be_valid), 64'd0);
    fr = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(fr, 0, 1'b0);
    drain();

    // Random frames, gaps, enable toggling and downstream backpressure.
    rand_ready = 1'b1;
    for (int f = 0; f < 40 && !aborted; f++) begin
      int len = $urandom_range(14, 1);
      fr = {};
      for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
      send_frame(fr, $urandom_range(2), 1'b1);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_rx_word_packer.md
ETH_RX_WORD_PACKER -- requirements
Module: eth_rx_word_packer

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 16'd1500, maximum payload bytes forwarded per frame (legal 4..65535).
REQ-002 SHALL have parameter BIG_ENDIAN, default 1'b1, 1 = first byte in [31:24], 0 = first byte in [7:0].
REQ-003 SHALL have port axi_tclk_i  in  1  clock; all logic rising-edge.
REQ-004 SHALL have port axi_tresetn_i  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port enable_i  in  1  permits start of a new frame.
REQ-006 SHALL have ports s_axis_tdata/tvalid/tlast  in  8/1/1  decoded payload bytes from the RX decoder.
REQ-007 SHALL have port s_axis_tready  out  1  byte accept.
REQ-008 SHALL have ports m_axis_tdata/tkeep/tvalid/tlast  out  32/4/1/1  packed word stream.
REQ-009 SHALL have port m_axis_tready  in  1  downstream accept.
REQ-010 SHALL have port byte_count_o  out  16  bytes received in the last completed frame (incl. dropped), saturating at 16'hFFFF.
REQ-011 SHALL have ports frame_done_o, frame_trunc_o  out  1/1  single-cycle status pulses.

Function
REQ-012 SHALL implement states IDLE, PACK, DROP; byte beat = s_axis_tvalid & s_axis_tready; word beat = m_axis_tvalid & m_axis_tready.
REQ-013 In IDLE, s_axis_tready SHALL equal enable_i & output register free; first byte beat moves to PACK (or to IDLE directly if it carries tlast).
REQ-014 enable_i deassertion mid-frame SHALL NOT stall or abort the current frame.
REQ-015 Bytes SHALL be packed in order per BIG_ENDIAN into a 4-byte assembly register with 2-bit lane index.
REQ-016 On the byte beat filling lane 3, or carrying tlast, the word SHALL load into a single output register, m_axis_tvalid asserting the next cycle (latency 1).
REQ-017 s_axis_tready SHALL be low only when the incoming byte would load the output register and that register holds a word not accepted in the current cycle; otherwise high in PACK/DROP.
REQ-018 Output tkeep SHALL be 4'b1111 for full words; for a partial last word of n bytes SHALL mark n valid lanes (BIG_ENDIAN: 1000/1100/1110; else 0001/0011/0111); unused lanes SHALL be zero.
REQ-019 m_axis_tdata/tkeep/tlast SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-020 Frame byte counter SHALL increment per byte beat, saturating at 16'hFFFF.
REQ-021 When byte MAX_BYTES is accepted without tlast, that word SHALL be emitted with tlast=1 and the FSM SHALL enter DROP.
REQ-022 In DROP, bytes SHALL be accepted (tready=1) and discarded until tlast inclusive, then return to IDLE.
REQ-023 On the byte beat carrying tlast, byte_count_o SHALL latch the final count and frame_done_o SHALL pulse for one cycle the next cycle.
REQ-024 frame_trunc_o SHALL pulse coincident with frame_done_o when the frame passed through DROP.
REQ-025 A byte beat with tlast SHALL reset the lane index and counter so the next frame starts at lane 0, count 0, with no idle cycle required.

Reset
REQ-026 On axi_tresetn_i=1: FSM=IDLE, lane index 0, counter 0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, s_axis_tready=0, byte_count_o=0, frame_done_o=0, frame_trunc_o=0.
REQ-027 Reset mid-frame SHALL discard the partial word and pending output word; no output beat follows reset release until a new frame is received.

Structure
REQ-028 State encoding and tkeep lookup constants SHALL live in the shared Ethernet-path package.
REQ-029 The output register and its stall logic SHALL be one sub-module, eth_axis_out_reg (32+4+1 bit payload).

Verification
REQ-030 8-byte frame 01..08, tready=1, BIG_ENDIAN=1 -> words 32'h01020304 (keep F), 32'h05060708 (keep F, tlast); byte_count_o=8, frame_done_o one pulse.
REQ-031 5-byte frame AA..EE -> 32'hAABBCCDD, then 32'hEE000000 keep 4'b1000 tlast; BIG_ENDIAN=0 -> 32'hDDCCBBAA, 32'h000000EE keep 4'b0001.
REQ-032 m_axis_tready low 32 cycles mid-frame -> s_axis_tready drops within one byte, words unchanged while stalled, no byte lost or duplicated.
REQ-033 MAX_BYTES=8, 12-byte frame -> two words, second with tlast, bytes 9..12 accepted and dropped; byte_count_o=12, frame_trunc_o pulse.
REQ-034 Back-to-back frames (tlast then next frame's first byte next cycle, 1-byte frame 0x5A) -> 32'h5A000000 keep 4'b1000 tlast, next frame aligned at lane 0.
REQ-035 Assert axi_tresetn_i after 3 bytes of a frame -> all outputs at reset values; next 4-byte frame 11..44 -> single word 32'h11223344 tlast.
